w0rm_core_register_file: RTL and testbench

//  Multi-ported general-purpose register file for the W0RM core: two read ports, one write port.

---
 rtl/w0rm_core_register_file_if.sv | 32 +++
 rtl/w0rm_core_register_file.sv | 122 ++++++++++++
 tb/tb_w0rm_core_register_file.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_core_register_file_if.sv
// rtl/w0rm_core_register_file_if.sv - decode/writeback/ALU-side bus of the W0RM register file
interface w0rm_core_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  alu_ready;
  logic                  reg_file_ready;
  logic                  decode_valid;
  logic                  rfetch_valid;
  logic [ADDR_WIDTH-1:0] port_read0_addr;
  logic [DATA_WIDTH-1:0] port_read0_data;
  logic [ADDR_WIDTH-1:0] port_read1_addr;
  logic [DATA_WIDTH-1:0] port_read1_data;
  logic [ADDR_WIDTH-1:0] port_write_addr;
  logic                  port_write_enable;
  logic [DATA_WIDTH-1:0] port_write_data;

  modport master (
    output flush, alu_ready, decode_valid,
    output port_read0_addr, port_read1_addr,
    output port_write_addr, port_write_enable, port_write_data,
    input  reg_file_ready, rfetch_valid, port_read0_data, port_read1_data
  );

  modport slave (
    input  flush, alu_ready, decode_valid,
    input  port_read0_addr, port_read1_addr,
    input  port_write_addr, port_write_enable, port_write_data,
    output reg_file_ready, rfetch_valid, port_read0_data, port_read1_data
  );
endinterface

// File: rtl/w0rm_core_register_file.sv
// rtl/w0rm_core_register_file.sv - 2R1W register file with registered operand fetch stage
// Optional macro W0RM_REGFILE_BYPASS_EN forwards same-edge write data to matching read ports.
module w0rm_core_register_file #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 16,
  parameter bit SINGLE_CYCLE  = 1'b1
) (
  input logic                       clk,
  input logic                       reset_n,
  w0rm_core_register_file_if.slave  bus
);
  localparam int ADDR_WIDTH = (NUM_REGISTERS > 2) ? $clog2(NUM_REGISTERS) : 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic                  wr_hit;
  logic                  ready;
  logic                  capture;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_d0;
  logic [DATA_WIDTH-1:0] out_d1;
  logic [DATA_WIDTH-1:0] rd0_val;
  logic [DATA_WIDTH-1:0] rd1_val;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_d0_q, s1_d0_d;
  logic [DATA_WIDTH-1:0] s1_d1_q, s1_d1_d;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < NUM_REGISTERS;
  endfunction

  assign wr_hit = bus.port_write_enable && addr_ok(bus.port_write_addr);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[bus.port_write_addr] = bus.port_write_data;
  end

  always_comb begin
    rd0_val = addr_ok(bus.port_read0_addr) ? regs_q[bus.port_read0_addr] : '0;
    rd1_val = addr_ok(bus.port_read1_addr) ? regs_q[bus.port_read1_addr] : '0;
`ifdef W0RM_REGFILE_BYPASS_EN
    if (wr_hit && bus.port_write_addr == bus.port_read0_addr) rd0_val = bus.port_write_data;
    if (wr_hit && bus.port_write_addr == bus.port_read1_addr) rd1_val = bus.port_write_data;
`endif
  end

  // Every stage moves together whenever the final stage can hand off or is empty.
  assign ready              = bus.alu_ready | ~out_valid;
  assign capture            = bus.decode_valid & ready & ~bus.flush;
  assign bus.reg_file_ready = ready;
  assign bus.rfetch_valid   = out_valid;
  assign bus.port_read0_data = out_d0;
  assign bus.port_read1_data = out_d1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d0_d    = s1_d0_q;
    s1_d1_d    = s1_d1_q;
    if (bus.flush)  s1_valid_d = 1'b0;
    else if (ready) s1_valid_d = bus.decode_valid;
    if (capture) begin
      s1_d0_d = rd0_val;
      s1_d1_d = rd1_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      s1_valid_q <= s1_valid_d;
      s1_d0_q    <= s1_d0_d;
      s1_d1_q    <= s1_d1_d;
    end
  end

  if (SINGLE_CYCLE) begin : g_single
    assign out_valid = s1_valid_q;
    assign out_d0    = s1_d0_q;
    assign out_d1    = s1_d1_q;
  end else begin : g_two
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_d0_q, s2_d0_d;
    logic [DATA_WIDTH-1:0] s2_d1_q, s2_d1_d;

    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_d0_d    = s2_d0_q;
      s2_d1_d    = s2_d1_q;
      if (bus.flush)  s2_valid_d = 1'b0;
      else if (ready) s2_valid_d = s1_valid_q;
      if (ready && s1_valid_q && !bus.flush) begin
        s2_d0_d = s1_d0_q;
        s2_d1_d = s1_d1_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_d0_q    <= '0;
        s2_d1_q    <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_d0_q    <= s2_d0_d;
        s2_d1_q    <= s2_d1_d;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_d0    = s2_d0_q;
    assign out_d1    = s2_d1_q;
  end
endmodule

// File: tb/tb_w0rm_core_register_file.sv
// tb/tb_w0rm_core_register_file.sv - scoreboard bench for single- and two-stage register file fetch
// Expectations follow W0RM_REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_w0rm_core_register_file;
  localparam int DW = 8;
  localparam int AW = 2;

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush, alu_ready, we, dv_a, dv_b;
  logic [AW-1:0] r0, r1, wa;
  logic [DW-1:0] wd;

  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [DW-1:0] mem_m [4];
  logic [DW-1:0] last_a0, last_a1, last_b0, last_b1;

  w0rm_core_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
  w0rm_core_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

  assign a_if.flush = flush;          assign b_if.flush = flush;
  assign a_if.alu_ready = alu_ready;  assign b_if.alu_ready = alu_ready;
  assign a_if.decode_valid = dv_a;    assign b_if.decode_valid = dv_b;
  assign a_if.port_read0_addr = r0;   assign b_if.port_read0_addr = r0;
  assign a_if.port_read1_addr = r1;   assign b_if.port_read1_addr = r1;
  assign a_if.port_write_addr = wa;   assign b_if.port_write_addr = wa;
  assign a_if.port_write_enable = we; assign b_if.port_write_enable = we;
  assign a_if.port_write_data = wd;   assign b_if.port_write_data = wd;

  w0rm_core_register_file #(.DATA_WIDTH(DW), .NUM_REGISTERS(4), .SINGLE_CYCLE(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if)
  );
  w0rm_core_register_file #(.DATA_WIDTH(DW), .NUM_REGISTERS(4), .SINGLE_CYCLE(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    q_a.push_back('{d0: d0, d1: d1});
  endtask

  task automatic push_b(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    q_b.push_back('{d0: d0, d1: d1});
  endtask

  task automatic pop_a(input string tag);
    exp_t e;
    tests++;
    assert (q_a.size() != 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      chk({tag, "_valid"}, 32'(a_if.rfetch_valid), 32'd1);
      chk({tag, "_d0"}, 32'(a_if.port_read0_data), 32'(e.d0));
      chk({tag, "_d1"}, 32'(a_if.port_read1_data), 32'(e.d1));
      last_a0 = e.d0;
      last_a1 = e.d1;
    end
  endtask

  task automatic pop_b(input string tag);
    exp_t e;
    tests++;
    assert (q_b.size() != 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      chk({tag, "_valid"}, 32'(b_if.rfetch_valid), 32'd1);
      chk({tag, "_d0"}, 32'(b_if.port_read0_data), 32'(e.d0));
      chk({tag, "_d1"}, 32'(b_if.port_read1_data), 32'(e.d1));
      last_b0 = e.d0;
      last_b1 = e.d1;
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; alu_ready = 1'b1; we = 1'b0;
    r0 = '0; r1 = '0; wa = '0; wd = '0; dv_a = 1'b0; dv_b = 1'b0;
    last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    tick(); tick();
    chk("rst_valid_a", 32'(a_if.rfetch_valid), 32'd0);
    chk("rst_d0_a", 32'(a_if.port_read0_data), 32'd0);
    chk("rst_d1_a", 32'(a_if.port_read1_data), 32'd0);
    chk("rst_valid_b", 32'(b_if.rfetch_valid), 32'd0);

    // Reset release, then the first accepted read of r0/r1.
    reset_n = 1'b1; r0 = 2'd0; r1 = 2'd1;
    tick();
    chk("idle_valid_a", 32'(a_if.rfetch_valid), 32'd0);
    chk("idle_ready_a", 32'(a_if.reg_file_ready), 32'd1);
    dv_a = 1'b1;
    push_a(mem_m[0], mem_m[1]);
    tick();
    pop_a("first");

    // Load r0..r3 through the write port with no fetch in flight.
    dv_a = 1'b0; we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa = AW'(i);
      wd = DW'(8'h11 * (i + 1));
      tick();
      mem_m[i] = DW'(8'h11 * (i + 1));
    end
    we = 1'b0;
    chk("drain_valid_a", 32'(a_if.rfetch_valid), 32'd0);
    chk("drain_hold_d0_a", 32'(a_if.port_read0_data), 32'(last_a0));

    dv_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0 = AW'(i);
      r1 = AW'(i + 1);
      push_a(mem_m[r0], mem_m[r1]);
      tick();
      pop_a("sweep_a");
    end

    // Write and read r2 on the same edge.
    r0 = 2'd2; r1 = 2'd3; we = 1'b1; wa = 2'd2; wd = 8'hA5;
`ifdef W0RM_REGFILE_BYPASS_EN
    push_a(8'hA5, mem_m[3]);
`else
    push_a(mem_m[2], mem_m[3]);
`endif
    tick();
    mem_m[2] = 8'hA5;
    we = 1'b0;
    pop_a("bypass");
    push_a(mem_m[2], mem_m[3]);
    tick();
    pop_a("after_write");

    // Stall with new addresses presented: outputs hold, nothing captured.
    alu_ready = 1'b0; r0 = 2'd0; r1 = 2'd1;
    #1;
    chk("stall_ready_comb", 32'(a_if.reg_file_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(a_if.rfetch_valid), 32'd1);
      chk("stall_d0", 32'(a_if.port_read0_data), 32'(last_a0));
      chk("stall_d1", 32'(a_if.port_read1_data), 32'(last_a1));
      chk("stall_ready", 32'(a_if.reg_file_ready), 32'd0);
    end
    alu_ready = 1'b1;
    push_a(mem_m[0], mem_m[1]);
    tick();
    pop_a("unstall");

    // Flush beats a pending accept; a write on the same edge still lands.
    flush = 1'b1; r0 = 2'd3; r1 = 2'd3; we = 1'b1; wa = 2'd1; wd = 8'h5A;
    tick();
    flush = 1'b0; we = 1'b0;
    mem_m[1] = 8'h5A;
    chk("flush_valid", 32'(a_if.rfetch_valid), 32'd0);
    chk("flush_hold_d0", 32'(a_if.port_read0_data), 32'(last_a0));
    r0 = 2'd1; r1 = 2'd1;
    push_a(mem_m[1], mem_m[1]);
    tick();
    pop_a("same_reg");
    dv_a = 1'b0;
    tick();
    chk("noacc_valid", 32'(a_if.rfetch_valid), 32'd0);
    chk("noacc_hold_d1", 32'(a_if.port_read1_data), 32'(last_a1));

    // Two-stage variant: same sweep, one extra edge of latency.
    dv_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0 = AW'(i);
      r1 = AW'(i + 1);
      push_b(mem_m[r0], mem_m[r1]);
      tick();
      if (i == 0) chk("b_latency_valid", 32'(b_if.rfetch_valid), 32'd0);
      else pop_b("sweep_b");
    end
    dv_b = 1'b0;
    tick();
    pop_b("sweep_b_last");
    tick();
    chk("b_drain_valid", 32'(b_if.rfetch_valid), 32'd0);

    // Flush must also kill a transfer still in the first stage.
    dv_b = 1'b1; r0 = 2'd0; r1 = 2'd0;
    tick();
    chk("b_s1_only_valid", 32'(b_if.rfetch_valid), 32'd0);
    flush = 1'b1; dv_b = 1'b0;
    tick();
    flush = 1'b0;
    chk("b_flush_valid0", 32'(b_if.rfetch_valid), 32'd0);
    tick();
    chk("b_flush_valid1", 32'(b_if.rfetch_valid), 32'd0);

    // Two-stage stall holds the output.
    dv_b = 1'b1; r0 = 2'd3; r1 = 2'd2;
    push_b(mem_m[3], mem_m[2]);
    tick();
    dv_b = 1'b0;
    tick();
    pop_b("b_pre_stall");
    alu_ready = 1'b0;
    tick(); tick();
    chk("b_stall_valid", 32'(b_if.rfetch_valid), 32'd1);
    chk("b_stall_d0", 32'(b_if.port_read0_data), 32'(last_b0));
    chk("b_stall_ready", 32'(b_if.reg_file_ready), 32'd0);
    alu_ready = 1'b1;
    tick();
    chk("b_release_valid", 32'(b_if.rfetch_valid), 32'd0);

    // Asynchronous reset between clock edges.
    dv_a = 1'b1; r0 = 2'd0; r1 = 2'd3;
    push_a(mem_m[0], mem_m[3]);
    tick();
    pop_a("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(a_if.rfetch_valid), 32'd0);
    chk("async_d0", 32'(a_if.port_read0_data), 32'd0);
    chk("async_d1", 32'(a_if.port_read1_data), 32'd0);
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    dv_a = 1'b0;
    tick();
    reset_n = 1'b1; dv_a = 1'b1; r0 = 2'd1; r1 = 2'd2;
    push_a(mem_m[1], mem_m[2]);
    tick();
    pop_a("post_reset");
    dv_a = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
